// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry in-order FIFO of {pc, instruction} pairs
// between fetch (valid/ready) and decode (hold), with synchronous flush and NOP when empty.
module if_id_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013),
  localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic [DATA_W-1:0] i_inst_data,
  input  logic              i_hold_flag,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc_addr,
  output logic [DATA_W-1:0] o_inst_data,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Accept/consume decisions look only at registered occupancy, so a pop from
  // full never lets the same-cycle push through.
  assign push = i_valid && !full && !i_flush;
  assign pop  = !empty && !i_hold_flag && !i_flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; stale entries are masked by count.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      pc_mem_q[wptr_q]   <= i_pc_addr;
      inst_mem_q[wptr_q] <= i_inst_data;
    end
  end

  assign o_ready     = !full;
  assign o_valid     = !empty;
  assign o_count     = count_q;
  assign o_pc_addr   = empty ? '0       : pc_mem_q[rptr_q];
  assign o_inst_data = empty ? NOP_INST : inst_mem_q[rptr_q];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=4 instances share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        hold;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] inst;

  logic        rdy2, vld2;
  logic [31:0] opc2, oinst2;
  logic [1:0]  cnt2;
  logic        rdy4, vld4;
  logic [31:0] opc4, oinst4;
  logic [2:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each entry is {pc, inst}, front = head of queue.
  logic [63:0] q2[$];
  logic [63:0] q4[$];

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .NOP_INST(NOP)) dut2 (
    .i_Clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(rdy2),
    .i_pc_addr(pc), .i_inst_data(inst), .i_hold_flag(hold), .i_flush(flush),
    .o_valid(vld2), .o_pc_addr(opc2), .o_inst_data(oinst2), .o_count(cnt2)
  );

  if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .NOP_INST(NOP)) dut4 (
    .i_Clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(rdy4),
    .i_pc_addr(pc), .i_inst_data(inst), .i_hold_flag(hold), .i_flush(flush),
    .o_valid(vld4), .o_pc_addr(opc4), .o_inst_data(oinst4), .o_count(cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string name, input int sz, input int depth,
                         input logic [63:0] head, input logic v, input logic r,
                         input logic [2:0] cnt, input logic [31:0] opc,
                         input logic [31:0] oinst);
    chk({name, "_valid"}, 64'(v),     64'(sz != 0));
    chk({name, "_ready"}, 64'(r),     64'(sz != depth));
    chk({name, "_count"}, 64'(cnt),   64'(sz));
    chk({name, "_pc"},    64'(opc),   (sz != 0) ? 64'(head[63:32]) : 64'h0);
    chk({name, "_inst"},  64'(oinst), (sz != 0) ? 64'(head[31:0])  : 64'(NOP));
  endtask

  task automatic check_all();
    chk_dut("d2", q2.size(), 2, (q2.size() != 0) ? q2[0] : 64'h0,
            vld2, rdy2, {1'b0, cnt2}, opc2, oinst2);
    chk_dut("d4", q4.size(), 4, (q4.size() != 0) ? q4[0] : 64'h0,
            vld4, rdy4, cnt4, opc4, oinst4);
  endtask

  // Applies one clock's worth of the queue rules to the model.
  task automatic model_step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                            input logic h, input logic f);
    bit do_pop, do_push;
    if (f) begin
      q2.delete();
      q4.delete();
    end else begin
      do_pop  = (q2.size() != 0) && !h;
      do_push = v && (q2.size() != 2);
      if (do_pop)  void'(q2.pop_front());
      if (do_push) q2.push_back({p, ins});
      do_pop  = (q4.size() != 0) && !h;
      do_push = v && (q4.size() != 4);
      if (do_pop)  void'(q4.pop_front());
      if (do_push) q4.push_back({p, ins});
    end
  endtask

  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                      input logic h, input logic f);
    i_valid = v;
    pc      = p;
    inst    = ins;
    hold    = h;
    flush   = f;
    model_step(v, p, ins, h, f);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    pc      = '0;
    inst    = '0;
    #1;
    check_all();
    #2 rst_n = 1'b1;

    // Streaming: one in, one out per cycle, count stays at 1
    step(1'b1, 32'h0, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h4, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h8, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'hC, 32'h44, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0,  1'b0, 1'b0);

    // Hold/fill, then release with 0x108 held stable until accepted
    step(1'b1, 32'h100, 32'h1001, 1'b1, 1'b0);
    step(1'b1, 32'h104, 32'h1041, 1'b1, 1'b0);
    step(1'b1, 32'h108, 32'h1081, 1'b1, 1'b0);
    step(1'b1, 32'h108, 32'h1081, 1'b1, 1'b0);
    step(1'b1, 32'h108, 32'h1081, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'h1081, 1'b0, 1'b0);
    step(1'b0, 32'h0,   32'h0,    1'b0, 1'b0);
    step(1'b0, 32'h0,   32'h0,    1'b0, 1'b0);
    step(1'b0, 32'h0,   32'h0,    1'b0, 1'b0);

    // Flush discards queue plus concurrent push; next push becomes head
    step(1'b1, 32'h1F0, 32'hAA, 1'b1, 1'b0);
    step(1'b1, 32'h1F4, 32'hBB, 1'b1, 1'b0);
    step(1'b1, 32'h200, 32'hCC, 1'b0, 1'b1);
    step(1'b1, 32'h300, 32'hDD, 1'b1, 1'b0);
    step(1'b0, 32'h0,   32'h0,  1'b0, 1'b0);

    // Hold on empty queue has no effect
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with two entries queued
    step(1'b1, 32'h400, 32'h55, 1'b1, 1'b0);
    step(1'b1, 32'h404, 32'h66, 1'b1, 1'b0);
    i_valid = 1'b0;
    hold    = 1'b0;
    #2 rst_n = 1'b0;
    q2.delete();
    q4.delete();
    #1;
    check_all();
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes, exercising pointer wrap
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    // Drain
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID decoupling stage: a DEPTH-entry in-order queue of {pc, instruction} pairs between fetch and decode. It replaces the single hold-capable IF/ID register with a valid/ready handshake on the fetch side, a hold input on the decode side, a synchronous flush for branch/jump redirects, and NOP presentation when empty. Fetch keeps running while decode is held, until the queue fills.

## Interface
- `ADDR_W`, 32, PC address width.
- `DATA_W`, 32, instruction width.
- `DEPTH`, 2, number of entries; power of two, ≥2.
- `NOP_INST`, 32'h00000013, instruction presented when the queue is empty (`addi x0,x0,0`); width DATA_W.
- `CNT_W`, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- `i_Clk` input 1: clock; all state updates on the rising edge.
- `i_reset` input 1: asynchronous, active-low reset.
- `i_valid` input 1: fetch presents a valid pc/instruction pair.
- `o_ready` output 1: queue accepts a pair this cycle; `!full`.
- `i_pc_addr` input ADDR_W: fetched PC.
- `i_inst_data` input DATA_W: fetched instruction.
- `i_hold_flag` input 1: decode stall; head entry is not consumed while high.
- `i_flush` input 1: discard all entries (redirect from ex).
- `o_valid` output 1: head entry valid; `count != 0`.
- `o_pc_addr` output ADDR_W: head PC; 0 when empty.
- `o_inst_data` output DATA_W: head instruction; NOP_INST when empty.
- `o_count` output CNT_W: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × (ADDR_W+DATA_W) register array, write pointer, read pointer, and occupancy counter. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push = `i_valid && o_ready && !i_flush`. Writes the pair at wptr and increments wptr.
- Pop = `o_valid && !i_hold_flag && !i_flush`. Increments rptr.
- Count update: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- Full (count == DEPTH):
  - o_ready = 0, so input is ignored even when a pop occurs in the same cycle. There is no same-cycle pass-through.
  - Fetch must hold its pc/inst stable until o_ready returns.
- Empty (count == 0):
  - o_valid = 0, o_inst_data = NOP_INST, o_pc_addr = 0.
  - Hold has no effect.
  - A push is not visible at the outputs until after the next edge (no bypass).
- Flush:
  - Synchronous and highest priority.
  - On the edge it sets wptr = rptr = 0 and count = 0, and discards both the concurrent push and the concurrent pop.
  - Array contents need not be cleared.
- Hold with non-empty queue: the head stays on the outputs unchanged, and pushes continue while not full.
- Outputs are combinational from the head-of-queue register and count only. There is no combinational path from i_valid, i_hold_flag, or i_flush to any output.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert is the integrator's duty):
  - wptr = rptr = count = 0.
  - o_valid = 0, o_ready = 1, o_count = 0, o_pc_addr = 0, o_inst_data = NOP_INST.
  - Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: a pair pushed on edge N appears at the outputs from edge N (after the update) when the queue was empty. Otherwise it appears behind the older entries.
- Throughput: one push and one pop per cycle in steady state, with no bubbles while 0 < count < DEPTH.
- o_ready falls the cycle after the DEPTH-th unmatched push. It rises the cycle after the first pop from full.
- Flush on edge N: o_valid = 0 and NOP is presented from edge N. The first post-flush push is accepted on edge N+1 or later.

## Test plan
- Reset: hold i_reset=0 mid-stream with count=2 → asynchronously o_valid=0, o_ready=1, o_count=0, o_inst_data=32'h00000013, o_pc_addr=0.
- Streaming: push pc 0x0,0x4,0x8,0xC with inst 0x11,0x22,0x33,0x44 on consecutive cycles, hold=0 → the same order appears one per cycle, o_count stays 1, no bubbles.
- Hold/fill: hold=1 and push pc 0x100, 0x104, 0x108 → o_count reaches 2 and o_ready=0. 0x108 is kept stable until accepted. Releasing hold yields 0x100, 0x104, 0x108 in order.
- Full with pop: count=2, hold=0, i_valid=1 → pop occurs, push is refused that cycle, o_count=1, o_ready=1 next cycle.
- Flush: count=2, assert i_flush with i_valid=1 (pc 0x200) and hold=0 → next cycle o_count=0 and NOP is presented; 0x200 is not enqueued. Pushing 0x300 afterwards appears as head.
- Wrap-around with DEPTH=4: 10 push/pop cycles with random hold → output sequence equals input sequence and o_count matches a reference model every cycle.
